// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: counter encodings, saturating
// counter arithmetic and the PC index/tag slicing used by every table access.
package branch_predictor_pkg;

  // Named states of the classic 2-bit counter
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  // Width-generic equivalents, valid for 1 <= bits <= 31
  function automatic int unsigned cnt_weak_nt(input int unsigned bits);
    return (32'd1 << (bits - 1)) - 32'd1;
  endfunction

  function automatic int unsigned cnt_weak_t(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction

  function automatic int unsigned cnt_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  function automatic int unsigned sat_inc(input int unsigned cnt, input int unsigned bits);
    return (cnt >= cnt_max(bits)) ? cnt : cnt + 32'd1;
  endfunction

  function automatic int unsigned sat_dec(input int unsigned cnt);
    return (cnt == 32'd0) ? cnt : cnt - 32'd1;
  endfunction

  // Instructions are word aligned, so PC[1:0] never takes part in the lookup
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int unsigned index_bits);
    return (pc >> 2) & ((64'd1 << index_bits) - 64'd1);
  endfunction

  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned index_bits);
    return pc >> (index_bits + 2);
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped predictor storage: two combinational read ports (IF lookup and
// EX update lookup) and one clocked write port with synchronous reset.
module bp_table
  import branch_predictor_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int INDEX_BITS = 6,
  parameter int TAG_W      = XLEN - INDEX_BITS - 2,
  parameter int CNT_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] ra_idx,
  output logic                  ra_valid,
  output logic [TAG_W-1:0]      ra_tag,
  output logic [XLEN-1:0]       ra_target,
  output logic [CNT_BITS-1:0]   ra_cnt,
  input  logic [INDEX_BITS-1:0] rb_idx,
  output logic                  rb_valid,
  output logic [TAG_W-1:0]      rb_tag,
  output logic [XLEN-1:0]       rb_target,
  output logic [CNT_BITS-1:0]   rb_cnt,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_valid,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [XLEN-1:0]       wr_target,
  input  logic [CNT_BITS-1:0]   wr_cnt
);

  localparam int                  ENTRIES = 1 << INDEX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_RST = CNT_BITS'(cnt_weak_nt(CNT_BITS));

  logic                valid_q  [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q    [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];

  // Reads see the pre-edge contents, so a same-cycle write is not bypassed
  assign ra_valid  = valid_q[ra_idx];
  assign ra_tag    = tag_q[ra_idx];
  assign ra_target = target_q[ra_idx];
  assign ra_cnt    = cnt_q[ra_idx];
  assign rb_valid  = valid_q[rb_idx];
  assign rb_tag    = tag_q[rb_idx];
  assign rb_target = target_q[rb_idx];
  assign rb_cnt    = cnt_q[rb_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_RST;
      end
    end else if (we) begin
      valid_q[wr_idx] <= wr_valid;
      cnt_q[wr_idx]   <= wr_cnt;
    end
  end

  // NOTE: tag and target are qualified by valid, so they are left out of reset
  // and can map onto plain RAM without a reset port.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: IF-stage BTB/BHT lookup, EX-stage training,
// mispredict/redirect generation and branch statistics counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int INDEX_BITS = 6,
  parameter int CNT_BITS   = 2,
  parameter int BHT_EN     = 1,
  parameter int STAT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   PCF,
  output logic              PredTakenF,
  output logic [XLEN-1:0]   PredTargetF,
  input  logic              BrValidE,
  input  logic [XLEN-1:0]   PCE,
  input  logic              BranchE,
  input  logic [XLEN-1:0]   BrTargetE,
  input  logic              PredTakenE,
  input  logic [XLEN-1:0]   PredTargetE,
  output logic              MispredictE,
  output logic [XLEN-1:0]   CorrectPCE,
  output logic [STAT_W-1:0] BrCount,
  output logic [STAT_W-1:0] MissCount
);

  localparam int                  TAG_W     = XLEN - INDEX_BITS - 2;
  localparam logic [CNT_BITS-1:0] CNT_ALLOC = CNT_BITS'(cnt_weak_t(CNT_BITS));

  logic [INDEX_BITS-1:0] idx_f, idx_e;
  logic [TAG_W-1:0]      tag_f, tag_e;
  logic                  valid_f, valid_e;
  logic [TAG_W-1:0]      rd_tag_f, rd_tag_e;
  logic [XLEN-1:0]       rd_target_f, rd_target_e;
  logic [CNT_BITS-1:0]   cnt_f, cnt_e;
  logic                  hit_f, hit_e;

  logic                  we;
  logic                  wr_valid;
  logic [XLEN-1:0]       wr_target;
  logic [CNT_BITS-1:0]   wr_cnt;

  assign idx_f = INDEX_BITS'(pc_index(64'(PCF), INDEX_BITS));
  assign tag_f = TAG_W'(pc_tag(64'(PCF), INDEX_BITS));
  assign idx_e = INDEX_BITS'(pc_index(64'(PCE), INDEX_BITS));
  assign tag_e = TAG_W'(pc_tag(64'(PCE), INDEX_BITS));

  bp_table #(
    .XLEN       (XLEN),
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W),
    .CNT_BITS   (CNT_BITS)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .ra_idx    (idx_f),
    .ra_valid  (valid_f),
    .ra_tag    (rd_tag_f),
    .ra_target (rd_target_f),
    .ra_cnt    (cnt_f),
    .rb_idx    (idx_e),
    .rb_valid  (valid_e),
    .rb_tag    (rd_tag_e),
    .rb_target (rd_target_e),
    .rb_cnt    (cnt_e),
    .we        (we),
    .wr_idx    (idx_e),
    .wr_valid  (wr_valid),
    .wr_tag    (tag_e),
    .wr_target (wr_target),
    .wr_cnt    (wr_cnt)
  );

  assign hit_f       = valid_f && (rd_tag_f == tag_f);
  assign hit_e       = valid_e && (rd_tag_e == tag_e);
  assign PredTakenF  = (BHT_EN != 0) ? (hit_f && cnt_f[CNT_BITS-1]) : hit_f;
  assign PredTargetF = PredTakenF ? rd_target_f : PCF + XLEN'(4);

  // NOTE: every output gets a default first so no path through the case
  // analysis can leave a value unassigned and infer a latch.
  always_comb begin
    we        = 1'b0;
    wr_valid  = 1'b1;
    wr_target = rd_target_e;
    wr_cnt    = cnt_e;
    if (BrValidE) begin
      if (hit_e) begin
        we = 1'b1;
        if (BranchE) wr_target = BrTargetE;
        if (BHT_EN != 0) begin
          wr_cnt = BranchE ? CNT_BITS'(sat_inc(32'(cnt_e), CNT_BITS))
                           : CNT_BITS'(sat_dec(32'(cnt_e)));
        end else begin
          wr_valid = BranchE;
        end
      end else if (BranchE) begin
        we        = 1'b1;
        wr_target = BrTargetE;
        wr_cnt    = CNT_ALLOC;
      end
    end
  end

  assign MispredictE = BrValidE &&
                       ((PredTakenE != BranchE) || (BranchE && (PredTargetE != BrTargetE)));
  assign CorrectPCE  = BranchE ? BrTargetE : PCE + XLEN'(4);

  // NOTE: registered state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      BrCount   <= '0;
      MissCount <= '0;
    end else begin
      if (BrValidE)    BrCount   <= BrCount + STAT_W'(1);
      if (MispredictE) MissCount <= MissCount + STAT_W'(1);
    end
  end

endmodule
